vector_multicycle_controller: RTL and testbench

- Multicycle control FSM that replaces the single-cycle decoder in the next-generation processor core.
- Sequences fetch, decode, memory, scalar ALU and branch steps, and holds the NZCV flags with full condition-code evaluation.
- Executes vector data-processing instructions as a lane loop, one lane per cycle, over a parametrised lane count.
- Drives the datapath muxes, the ALU and the scalar/vector register-file and memory write enables.

---
 rtl/vector_multicycle_controller.sv | 201 ++++++++++++++++++++
 tb/tb_vector_multicycle_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_multicycle_controller.sv
// Multicycle controller: scalar fetch/decode/memory/ALU/branch steps plus a one-lane-per-cycle vector loop.
// Latency fetch-to-fetch 2..5 scalar, 2+NLANES vector; no backpressure, advances every clock.
module vector_multicycle_controller #(
    parameter  int NLANES = 4,
    localparam int LANE_W = $clog2(NLANES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        Cond,
    input  logic [1:0]        Op,
    input  logic [7:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic [3:0]        ALUFlags,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemW,
    output logic              IRWrite,
    output logic              RegSW,
    output logic              RegVW,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [3:0]        ALUControl,
    output logic [LANE_W-1:0] Lane,
    output logic [3:0]        Flags,
    output logic              Illegal
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_LSR = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, VEXEC
    } state_t;

    state_t            state, state_nx;
    logic [LANE_W-1:0] lane_cnt;
    logic              vbit, ibit, sbit, last_lane;
    logic [3:0]        cmd;
    logic              n_f, z_f, c_f, v_f, condex, cond_bad, instr_bad;
    logic [3:0]        dp_alu, v_alu;
    logic              dp_ok, dp_arith, dp_nowr, v_ok;
    logic              pcw, irw, memw, regsw, regvw;
    logic              unused_funct;

    assign vbit         = Funct[6];
    assign ibit         = Funct[5];
    assign cmd          = Funct[4:1];
    assign sbit         = Funct[0];
    assign unused_funct = Funct[7];
    assign last_lane    = (lane_cnt == LANE_W'(NLANES - 1));
    assign {n_f, z_f, c_f, v_f} = Flags;
    assign cond_bad     = (Cond == 4'hF);
    assign Lane         = lane_cnt;

    always_comb begin
        dp_alu   = ALU_ADD;
        dp_ok    = 1'b1;
        dp_arith = 1'b0;
        dp_nowr  = 1'b0;
        case (cmd)
            4'b0100: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            4'b0000: dp_alu = ALU_AND;
            4'b1101: dp_alu = ALU_LSR;
            4'b1010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; dp_nowr = 1'b1; end
            default: dp_ok = 1'b0;
        endcase
        v_alu = ALU_ADD;
        v_ok  = 1'b1;
        case (cmd)
            4'b0100: v_alu = ALU_ADD;
            4'b0010: v_alu = ALU_SUB;
            4'b1001: v_alu = ALU_MUL;
            default: v_ok = 1'b0;
        endcase
    end

    always_comb begin
        condex = 1'b0;
        case (Cond)
            4'b0000: condex = z_f;
            4'b0001: condex = !z_f;
            4'b0010: condex = c_f;
            4'b0011: condex = !c_f;
            4'b0100: condex = n_f;
            4'b0101: condex = !n_f;
            4'b0110: condex = v_f;
            4'b0111: condex = !v_f;
            4'b1000: condex = c_f && !z_f;
            4'b1001: condex = !c_f || z_f;
            4'b1010: condex = (n_f == v_f);
            4'b1011: condex = (n_f != v_f);
            4'b1100: condex = !z_f && (n_f == v_f);
            4'b1101: condex = z_f || (n_f != v_f);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign instr_bad = (Op == 2'b11) || ((Op == 2'b00) && (vbit ? !v_ok : !dp_ok));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            lane_cnt <= '0;
            Flags    <= 4'b0000;
        end else begin
            state <= state_nx;
            if (state == VEXEC)
                lane_cnt <= last_lane ? '0 : lane_cnt + LANE_W'(1);
            // Only C and V survive logical ops; NZ always come from the result.
            if (state == ALUWB && sbit && condex)
                Flags <= {ALUFlags[3:2], dp_arith ? ALUFlags[1:0] : Flags[1:0]};
        end
    end

    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:  state_nx = DECODE;
            DECODE: begin
                state_nx = FETCH;
                if (condex && !instr_bad) begin
                    case (Op)
                        2'b01:   state_nx = MEMADR;
                        2'b10:   state_nx = BRANCH;
                        2'b00:   state_nx = vbit ? VEXEC : (ibit ? EXECI : EXECR);
                        default: state_nx = FETCH;
                    endcase
                end
            end
            EXECR, EXECI: state_nx = ALUWB;
            MEMADR:       state_nx = sbit ? MEMRD : MEMWR;
            MEMRD:        state_nx = MEMWB;
            VEXEC:        state_nx = last_lane ? FETCH : VEXEC;
            default:      state_nx = FETCH;
        endcase
    end

    always_comb begin
        pcw        = 1'b0;
        irw        = 1'b0;
        memw       = 1'b0;
        regsw      = 1'b0;
        regvw      = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = (Op == 2'b01) ? 2'b01 : ((Op == 2'b10) ? 2'b10 : 2'b00);
        RegSrc     = {(Op == 2'b01) && !sbit, Op == 2'b10};
        Illegal    = 1'b0;
        case (state)
            FETCH: begin
                irw = 1'b1; pcw = 1'b1;
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                Illegal = cond_bad || (condex && instr_bad);
            end
            EXECR, EXECI: begin
                ALUSrcB = {1'b0, ibit}; ALUControl = dp_alu;
            end
            ALUWB: begin
                ALUSrcB = {1'b0, ibit}; ALUControl = dp_alu;
                regsw = condex && !dp_nowr && (Rd != 4'hF);
                pcw   = condex && !dp_nowr && (Rd == 4'hF);
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regsw = (Rd != 4'hF);
                pcw   = (Rd == 4'hF);
            end
            MEMWR: begin AdrSrc = 1'b1; memw = 1'b1; end
            BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; pcw = 1'b1;
            end
            VEXEC: begin
                ALUSrcB = {1'b0, ibit}; ResultSrc = 2'b10;
                ALUControl = v_alu; regvw = 1'b1;
            end
            default: ;
        endcase
    end

    // FETCH is the reset state and asserts PC/IR writes, so every enable is masked by reset.
    assign PCWrite = pcw   && reset_n;
    assign IRWrite = irw   && reset_n;
    assign MemW    = memw  && reset_n;
    assign RegSW   = regsw && reset_n;
    assign RegVW   = regvw && reset_n;
endmodule

// File: tb/tb_vector_multicycle_controller.sv
// Bench for vector_multicycle_controller: directed instruction table, reset/lane corner cases, random stream vs model.
module tb_vector_multicycle_controller;
    localparam int NL = 4;
    localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_LSR = 3, A_MUL = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [7:0] Funct;

    logic       PCWrite, AdrSrc, MemW, IRWrite, RegSW, RegVW, ALUSrcA, Illegal;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, Lane;
    logic [3:0] ALUControl, Flags;

    logic       PCWrite8, AdrSrc8, MemW8, IRWrite8, RegSW8, RegVW8, ALUSrcA8, Illegal8;
    logic [1:0] ResultSrc8, ALUSrcB8, ImmSrc8, RegSrc8;
    logic [2:0] Lane8;
    logic [3:0] ALUControl8, Flags8;

    vector_multicycle_controller #(.NLANES(NL)) dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW),
        .IRWrite(IRWrite), .RegSW(RegSW), .RegVW(RegVW), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .Lane(Lane), .Flags(Flags), .Illegal(Illegal));

    vector_multicycle_controller #(.NLANES(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite8), .AdrSrc(AdrSrc8), .MemW(MemW8),
        .IRWrite(IRWrite8), .RegSW(RegSW8), .RegVW(RegVW8), .ResultSrc(ResultSrc8),
        .ALUSrcA(ALUSrcA8), .ALUSrcB(ALUSrcB8), .ImmSrc(ImmSrc8), .RegSrc(RegSrc8),
        .ALUControl(ALUControl8), .Lane(Lane8), .Flags(Flags8), .Illegal(Illegal8));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [3:0]  af;
        logic [27:0] val;
        logic [27:0] care;
    } step_t;
    step_t      exp_q[$];
    logic [3:0] mflags;

    typedef struct {
        string      nm;
        logic [3:0] c;
        logic [1:0] op;
        logic [7:0] f;
        logic [3:0] rd;
        logic [3:0] af;
        int         cyc, pcw, regsw, memw, regvw, ill;
        logic [3:0] flags;
    } vec_t;
    vec_t tv[19];

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [27:0] act_word();
        return {Flags, RegSrc, ImmSrc, PCWrite, IRWrite, MemW, RegSW, RegVW, Illegal,
                AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, 4'(Lane)};
    endfunction

    // ARM condition codes come in pairs: odd codes are the negation of the even one.
    function automatic bit cond_pass(logic [3:0] c, logic [3:0] fl);
        bit n, z, cf, v, base;
        {n, z, cf, v} = fl;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic push(string nm, logic [3:0] af, logic pcw, logic irw, logic memw,
                        logic regsw, logic regvw, logic ill, int adr, int res, int sa,
                        int sb, int alu, int rsrc, int isrc, int lane);
        step_t s;
        s.name = nm; s.af = af; s.val = '0; s.care = '0;
        s.val[27:24] = mflags; s.care[27:24] = 4'hF;
        s.val[19:14] = {pcw, irw, memw, regsw, regvw, ill}; s.care[19:14] = '1;
        if (rsrc >= 0) begin s.val[23:22] = 2'(rsrc); s.care[23:22] = '1; end
        if (isrc >= 0) begin s.val[21:20] = 2'(isrc); s.care[21:20] = '1; end
        if (adr >= 0)  begin s.val[13] = 1'(adr);     s.care[13] = 1'b1;  end
        if (res >= 0)  begin s.val[12:11] = 2'(res);  s.care[12:11] = '1; end
        if (sa >= 0)   begin s.val[10] = 1'(sa);      s.care[10] = 1'b1;  end
        if (sb >= 0)   begin s.val[9:8] = 2'(sb);     s.care[9:8] = '1;   end
        if (alu >= 0)  begin s.val[7:4] = 4'(alu);    s.care[7:4] = '1;   end
        s.val[3:0] = 4'(lane); s.care[3:0] = '1;
        exp_q.push_back(s);
    endtask

    // Expands one instruction into its expected per-cycle control trace.
    task automatic build(logic [3:0] c, logic [1:0] op, logic [7:0] f, logic [3:0] rd);
        bit v, i, sl, pass, ok, arith, nowr, ill;
        logic [3:0] cmd, af;
        int alu, isrc, rsrc;
        v = f[6]; i = f[5]; cmd = f[4:1]; sl = f[0];
        ok = 1; arith = 0; nowr = 0; alu = A_ADD;
        if (v) begin
            if (cmd == 4'd4) alu = A_ADD;
            else if (cmd == 4'd2) alu = A_SUB;
            else if (cmd == 4'd9) alu = A_MUL;
            else ok = 0;
        end else begin
            if (cmd == 4'd4)       begin alu = A_ADD; arith = 1; end
            else if (cmd == 4'd2)  begin alu = A_SUB; arith = 1; end
            else if (cmd == 4'd0)  alu = A_AND;
            else if (cmd == 4'd13) alu = A_LSR;
            else if (cmd == 4'd10) begin alu = A_SUB; arith = 1; nowr = 1; end
            else ok = 0;
        end
        if (op == 2'b11 || op == 2'b00) ok = (op == 2'b00) && ok;
        else ok = 1;
        pass = (c != 4'hF) && cond_pass(c, mflags);
        ill  = (c == 4'hF) || (pass && !ok);
        isrc = (op == 2'b11) ? -1 : int'(op);
        rsrc = (op == 2'b11) ? -1 : ((op == 2'b01 && !sl) ? 2 : 0) + ((op == 2'b10) ? 1 : 0);
        push("fetch", 4'($urandom), 1, 1, 0, 0, 0, 0, 0, 2, 1, 2, A_ADD, -1, -1, 0);
        push("decode", 4'($urandom), 0, 0, 0, 0, 0, ill, -1, 2, 1, 2, -1, rsrc, isrc, 0);
        if (!pass || !ok) return;
        case (op)
            2'b01: begin
                push("memadr", 4'($urandom), 0, 0, 0, 0, 0, 0, -1, -1, -1, 1, A_ADD, -1, -1, 0);
                if (sl) begin
                    push("memrd", 4'($urandom), 0, 0, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1, 0);
                    push("memwb", 4'($urandom), rd == 15, 0, 0, rd != 15, 0, 0, -1, 1, -1, -1, -1, -1, -1, 0);
                end else
                    push("memwr", 4'($urandom), 0, 0, 1, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1, 0);
            end
            2'b10: push("branch", 4'($urandom), 1, 0, 0, 0, 0, 0, -1, 2, 0, 1, -1, -1, -1, 0);
            default: begin
                if (v) begin
                    for (int l = 0; l < NL; l++)
                        push("vexec", 4'($urandom), 0, 0, 0, 0, 1, 0, -1, 2, 0, int'(i), alu, -1, -1, l);
                end else begin
                    push("exec", 4'($urandom), 0, 0, 0, 0, 0, 0, -1, -1, -1, int'(i), alu, -1, -1, 0);
                    af = 4'($urandom_range(1, 15));
                    push("aluwb", af, !nowr && rd == 15, 0, 0, !nowr && rd != 15, 0, 0, -1, 0, -1, -1, -1, -1, -1, 0);
                    if (sl) mflags = {af[3:2], arith ? af[1:0] : mflags[1:0]};
                end
            end
        endcase
    endtask

    task automatic run_queue();
        step_t s;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            ALUFlags = s.af;
            @(negedge clk);
            checks++;
            if ((act_word() & s.care) !== (s.val & s.care)) begin
                failures++;
                $display("FAIL step_%s actual=%h required=%h care=%h", s.name, act_word(), s.val, s.care);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        #3 check("rst_enables", 32'({PCWrite, IRWrite, MemW, RegSW, RegVW, Illegal}), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        mflags = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, pcw, regsw, memw, regvw, ill, cnt;
        bit done;
        logic [1:0] op;
        logic [3:0] c, rd;
        logic [7:0] f;
        logic [3:0] cmds[6] = '{4'd4, 4'd2, 4'd0, 4'd13, 4'd10, 4'd9};

        tv[0]  = '{"adds",     4'hE, 2'b00, 8'h09, 4'h1, 4'h6, 4, 0, 1, 0, 0, 0, 4'h6};
        tv[1]  = '{"add_eq",   4'h0, 2'b00, 8'h08, 4'h1, 4'hF, 2, 0, 0, 0, 0, 0, 4'h0};
        tv[2]  = '{"ldr_pc",   4'hE, 2'b01, 8'h01, 4'hF, 4'h0, 5, 1, 0, 0, 0, 0, 4'h0};
        tv[3]  = '{"ldr_r2",   4'hE, 2'b01, 8'h01, 4'h2, 4'h0, 5, 0, 1, 0, 0, 0, 4'h0};
        tv[4]  = '{"str",      4'hE, 2'b01, 8'h00, 4'h3, 4'h0, 4, 0, 0, 1, 0, 0, 4'h0};
        tv[5]  = '{"b",        4'hE, 2'b10, 8'h80, 4'h0, 4'h0, 3, 1, 0, 0, 0, 0, 4'h0};
        tv[6]  = '{"addv",     4'hE, 2'b00, 8'h49, 4'hF, 4'hF, 6, 0, 0, 0, 4, 0, 4'h0};
        tv[7]  = '{"mulv",     4'hE, 2'b00, 8'h52, 4'h2, 4'h0, 6, 0, 0, 0, 4, 0, 4'h0};
        tv[8]  = '{"vbad",     4'hE, 2'b00, 8'h40, 4'h2, 4'h0, 2, 0, 0, 0, 0, 1, 4'h0};
        tv[9]  = '{"op11",     4'hE, 2'b11, 8'hC0, 4'h2, 4'h0, 2, 0, 0, 0, 0, 1, 4'h0};
        tv[10] = '{"cond_nv",  4'hF, 2'b00, 8'h08, 4'h1, 4'h0, 2, 0, 0, 0, 0, 1, 4'h0};
        tv[11] = '{"cmps_pc",  4'hE, 2'b00, 8'h15, 4'hF, 4'hB, 4, 0, 0, 0, 0, 0, 4'hB};
        tv[12] = '{"ands",     4'hE, 2'b00, 8'h01, 4'h4, 4'hF, 4, 0, 1, 0, 0, 0, 4'hC};
        tv[13] = '{"add_pc",   4'hE, 2'b00, 8'h08, 4'hF, 4'h5, 4, 1, 0, 0, 0, 0, 4'h0};
        tv[14] = '{"dp_bad",   4'hE, 2'b00, 8'h02, 4'h1, 4'h0, 2, 0, 0, 0, 0, 1, 4'h0};
        tv[15] = '{"lsrs_imm", 4'hE, 2'b00, 8'h3B, 4'h5, 4'h4, 4, 0, 1, 0, 0, 0, 4'h4};
        tv[16] = '{"subs_ne",  4'h1, 2'b00, 8'h05, 4'h6, 4'h3, 4, 0, 1, 0, 0, 0, 4'h3};
        tv[17] = '{"addv_eq",  4'h0, 2'b00, 8'h48, 4'h1, 4'h0, 2, 0, 0, 0, 0, 0, 4'h0};
        tv[18] = '{"op11_eq",  4'h0, 2'b11, 8'hC0, 4'h1, 4'h0, 2, 0, 0, 0, 0, 0, 4'h0};

        reset_n = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 8'h08; Rd = 4'h1; ALUFlags = 4'h0;
        #3;
        check("reset_enables", 32'({PCWrite, IRWrite, MemW, RegSW, RegVW, Illegal}), 32'd0);
        check("reset_flags", 32'(Flags), 32'd0);
        check("reset_lane", 32'(Lane), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        foreach (tv[k]) begin
            do_reset();
            Cond = tv[k].c; Op = tv[k].op; Funct = tv[k].f; Rd = tv[k].rd; ALUFlags = tv[k].af;
            pcw = 0; regsw = 0; memw = 0; regvw = 0; ill = 0; cyc = -1; done = 0;
            @(negedge clk);
            regsw += int'(RegSW); memw += int'(MemW); regvw += int'(RegVW); ill += int'(Illegal);
            for (int n = 1; n < 40 && !done; n++) begin
                @(negedge clk);
                if (IRWrite) begin
                    done = 1; cyc = n;
                end else begin
                    pcw += int'(PCWrite); regsw += int'(RegSW); memw += int'(MemW);
                    regvw += int'(RegVW); ill += int'(Illegal);
                end
            end
            check({tv[k].nm, "_cycles"}, 32'(cyc), 32'(tv[k].cyc));
            check({tv[k].nm, "_pcwrite"}, 32'(pcw), 32'(tv[k].pcw));
            check({tv[k].nm, "_regsw"}, 32'(regsw), 32'(tv[k].regsw));
            check({tv[k].nm, "_memw"}, 32'(memw), 32'(tv[k].memw));
            check({tv[k].nm, "_regvw"}, 32'(regvw), 32'(tv[k].regvw));
            check({tv[k].nm, "_illegal"}, 32'(ill), 32'(tv[k].ill));
            check({tv[k].nm, "_flags"}, 32'(Flags), 32'(tv[k].flags));
        end

        // Reset in the middle of a MULV after flags were made non-zero.
        do_reset();
        Cond = 4'hE; Op = 2'b00; Funct = 8'h09; Rd = 4'h1;
        build(4'hE, 2'b00, 8'h09, 4'h1);
        run_queue();
        Cond = 4'hE; Op = 2'b00; Funct = 8'h52; Rd = 4'h2;
        @(negedge clk);
        check("pre_mulv_flags", 32'(Flags), 32'(mflags));
        repeat (4) @(negedge clk);
        check("mulv_lane2", 32'({RegVW, 2'(Lane)}), 32'({1'b1, 2'd2}));
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_regvw", 32'(RegVW), 32'd0);
        check("mid_rst_lane", 32'(Lane), 32'd0);
        check("mid_rst_flags", 32'(Flags), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_fetch", 32'({IRWrite, 2'(Lane), Flags}), 32'({1'b1, 2'd0, 4'h0}));

        // Eight-lane instance runs the same ADDV.
        do_reset();
        Cond = 4'hE; Op = 2'b00; Funct = 8'h48; Rd = 4'h7;
        cnt = 0; cyc = -1; done = 0;
        @(negedge clk);
        for (int n = 1; n < 40 && !done; n++) begin
            @(negedge clk);
            if (IRWrite8) begin
                done = 1; cyc = n;
            end else if (RegVW8) begin
                check("lane8_index", 32'(Lane8), 32'(cnt));
                check("lane8_aluctl", 32'(ALUControl8), 32'(A_ADD));
                cnt++;
            end
        end
        check("lane8_regvw_count", 32'(cnt), 32'd8);
        check("lane8_cycles", 32'(cyc), 32'd10);

        // Random instruction stream against the model.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: op = 2'b00;
                5, 6:          op = 2'b01;
                7, 8:          op = 2'b10;
                default:       op = 2'b11;
            endcase
            c  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            f  = 8'($urandom);
            f[7] = op[1];
            if ($urandom_range(0, 9) < 8) f[4:1] = cmds[$urandom_range(0, 5)];
            if (op == 2'b00 && $urandom_range(0, 2) != 0) f[6] = 1'b0;
            Cond = c; Op = op; Funct = f; Rd = rd;
            build(c, op, f, rd);
            run_queue();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
